// File: rtl/m_mem_ctrl_pkg.sv
// Shared access-width codes, controller state codes and byte-lane helpers
// for the M-stage data-memory controller.
package m_mem_ctrl_pkg;

  localparam logic [2:0] DM_w  = 3'd0;
  localparam logic [2:0] DM_h  = 3'd1;
  localparam logic [2:0] DM_hu = 3'd2;
  localparam logic [2:0] DM_b  = 3'd3;
  localparam logic [2:0] DM_bu = 3'd4;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  function automatic logic dmop_legal(input logic [2:0] op);
    logic ok;
    case (op)
      DM_w, DM_h, DM_hu, DM_b, DM_bu: ok = 1'b1;
      default:                        ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic misaligned(input logic [2:0] op, input logic [1:0] lo);
    logic bad;
    case (op)
      DM_w:        bad = (lo != 2'b00);
      DM_h, DM_hu: bad = lo[0];
      default:     bad = 1'b0;
    endcase
    return bad;
  endfunction

  // Loads always fetch the whole word; stores enable only the written lanes.
  function automatic logic [3:0] lane_be(input logic [2:0] op, input logic we,
                                         input logic [1:0] lo);
    logic [3:0] be;
    if (!we) begin
      be = 4'b1111;
    end else begin
      case (op)
        DM_h, DM_hu: be = lo[1] ? 4'b1100 : 4'b0011;
        DM_b, DM_bu: be = 4'b0001 << lo;
        default:     be = 4'b1111;
      endcase
    end
    return be;
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [2:0] op, input logic [31:0] wdata);
    logic [31:0] rep;
    case (op)
      DM_h, DM_hu: rep = {2{wdata[15:0]}};
      DM_b, DM_bu: rep = {4{wdata[7:0]}};
      default:     rep = wdata;
    endcase
    return rep;
  endfunction

endpackage

// File: rtl/m_ld_ext.sv
// Load extension: selects the addressed halfword/byte lane of a bus word
// and sign- or zero-extends it according to the access code.
module m_ld_ext
  import m_mem_ctrl_pkg::*;
(
  input  logic [1:0]  Addr,
  input  logic [31:0] Data,
  input  logic [2:0]  DMOp,
  output logic [31:0] DOut
);

  logic [15:0] half_s;
  logic [7:0]  byte_s;

  always_comb begin
    half_s = Addr[1] ? Data[31:16] : Data[15:0];
    case (Addr)
      2'd0:    byte_s = Data[7:0];
      2'd1:    byte_s = Data[15:8];
      2'd2:    byte_s = Data[23:16];
      default: byte_s = Data[31:24];
    endcase
    case (DMOp)
      DM_h:    DOut = {{16{half_s[15]}}, half_s};
      DM_hu:   DOut = {16'h0000, half_s};
      DM_b:    DOut = {{24{byte_s[7]}}, byte_s};
      DM_bu:   DOut = {24'h00_0000, byte_s};
      default: DOut = Data;
    endcase
  end

endmodule

// File: rtl/m_mem_ctrl.sv
// M-stage data-memory controller: turns one load/store into a req/ready bus
// transaction, stalls the pipe while it is outstanding, registers the result.
module m_mem_ctrl
  import m_mem_ctrl_pkg::*;
#(
  parameter logic [31:0] DM_BASE  = 32'h0000_0000,
  parameter logic [31:0] DM_SIZE  = 32'h0000_3000,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m_valid,
  input  logic        m_we,
  input  logic [2:0]  DMOp,
  input  logic [31:0] Addr,
  input  logic [31:0] WData,
  input  logic        flush,
  input  logic        pipe_en,
  output logic        stall,
  output logic [31:0] rd_data,
  output logic        done,
  output logic        exc_adel,
  output logic        exc_ades,
  output logic        bus_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  localparam int unsigned WCW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WCW-1:0] WAIT_LIM = WCW'(MAX_WAIT);

  logic [1:0]     state_q, state_d;
  logic [31:0]    rd_data_q, rd_data_d;
  logic           done_q, done_d;
  logic           bus_err_q, bus_err_d;
  logic           mem_req_q, mem_req_d;
  logic           mem_we_q, mem_we_d;
  logic [31:0]    mem_addr_q, mem_addr_d;
  logic [3:0]     mem_be_q, mem_be_d;
  logic [31:0]    mem_wdata_q, mem_wdata_d;
  logic [2:0]     op_q, op_d;
  logic [1:0]     lo_q, lo_d;
  logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
  logic           drop_q, drop_d;

  logic [32:0]    offset_s;
  logic           in_win_s;
  logic           bad_s;
  logic           accept_s;
  logic           drop_now_s;
  logic [31:0]    ext_s;

  m_ld_ext u_ld_ext (
    .Addr (lo_q),
    .Data (mem_rdata),
    .DMOp (op_q),
    .DOut (ext_s)
  );

  // Borrow out of the 33-bit subtraction flags addresses below the window.
  always_comb begin
    offset_s = {1'b0, Addr} - {1'b0, DM_BASE};
    in_win_s = !offset_s[32] && (offset_s[31:0] < DM_SIZE);
    bad_s    = !dmop_legal(DMOp) || misaligned(DMOp, Addr[1:0]) || !in_win_s;
    accept_s = (state_q == IDLE) && m_valid && !bad_s && !flush;
  end

  assign stall     = accept_s || (state_q == BUSY);
  assign exc_adel  = (state_q == IDLE) && m_valid && !m_we && bad_s && !flush;
  assign exc_ades  = (state_q == IDLE) && m_valid &&  m_we && bad_s && !flush;
  assign rd_data   = rd_data_q;
  assign done      = done_q;
  assign bus_err   = bus_err_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;

  // Next-state and datapath for the IDLE/BUSY/DONE access sequencer.
  always_comb begin
    state_d     = state_q;
    rd_data_d   = rd_data_q;
    done_d      = done_q;
    bus_err_d   = 1'b0;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    op_d        = op_q;
    lo_d        = lo_q;
    wait_cnt_d  = wait_cnt_q;
    drop_d      = drop_q;
    drop_now_s  = drop_q || flush;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          state_d     = BUSY;
          mem_req_d   = 1'b1;
          mem_we_d    = m_we;
          mem_addr_d  = {Addr[31:2], 2'b00};
          mem_be_d    = lane_be(DMOp, m_we, Addr[1:0]);
          mem_wdata_d = lane_wdata(DMOp, WData);
          op_d        = DMOp;
          lo_d        = Addr[1:0];
          wait_cnt_d  = {WCW{1'b0}};
          drop_d      = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        drop_d = drop_now_s;
        // A flushed access still finishes on the bus; only its result is dropped.
        if (mem_ready) begin
          mem_req_d  = 1'b0;
          wait_cnt_d = {WCW{1'b0}};
          drop_d     = 1'b0;
          if (drop_now_s) begin
            state_d = IDLE;
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
            if (!mem_we_q) begin
              rd_data_d = ext_s;
            end else begin
              rd_data_d = rd_data_q;
            end
          end
        end else if (wait_cnt_q == WAIT_LIM) begin
          mem_req_d  = 1'b0;
          wait_cnt_d = {WCW{1'b0}};
          drop_d     = 1'b0;
          bus_err_d  = 1'b1;
          rd_data_d  = 32'h0000_0000;
          if (drop_now_s) begin
            state_d = IDLE;
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end else begin
          wait_cnt_d = wait_cnt_q + {{(WCW-1){1'b0}}, 1'b1};
        end
      end
      DONE: begin
        if (flush || pipe_en) begin
          state_d = IDLE;
          done_d  = 1'b0;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d   = IDLE;
        done_d    = 1'b0;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      rd_data_q   <= 32'h0000_0000;
      done_q      <= 1'b0;
      bus_err_q   <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h0000_0000;
      mem_be_q    <= 4'b0000;
      mem_wdata_q <= 32'h0000_0000;
      op_q        <= 3'd0;
      lo_q        <= 2'd0;
      wait_cnt_q  <= {WCW{1'b0}};
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_data_q   <= rd_data_d;
      done_q      <= done_d;
      bus_err_q   <= bus_err_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      op_q        <= op_d;
      lo_q        <= lo_d;
      wait_cnt_q  <= wait_cnt_d;
      drop_q      <= drop_d;
    end
  end

endmodule
